reg_file_scoreboard: RTL and testbench

//  Parametrised multi-read-port register file with a per-register pending-write scoreboard.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_rd_port.sv | 39 +++
 rtl/reg_file_scoreboard.sv | 71 +++++++
 tb/tb_reg_file_scoreboard.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and the address-validity rule used by the write, issue and read
// paths of the scoreboarded register file.
package reg_file_pkg;

    localparam int unsigned ZERO_ADDR     = 0;
    localparam int          DEFAULT_WIDTH = 32;
    localparam int          DEFAULT_DEPTH = 8;

    // An address is usable when it names a real register and is not the hardwired zero.
    function automatic logic addr_valid(input int unsigned addr,
                                        input int unsigned depth,
                                        input int          zero_reg);
        return (addr < depth) && !((zero_reg != 0) && (addr == ZERO_ADDR));
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: register mux, write-back bypass and pending-flag mask.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AW       = $clog2(DEFAULT_DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]          addr,
    input  logic [DEPTH*WIDTH-1:0] regs,
    input  logic [DEPTH-1:0]       pend_bits,
    input  logic                   wr_ok,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       operand,
    output logic                   busy
);

    // A forwarded write always reports not-pending; a same-cycle issue only shows next cycle.
    always_comb begin
        operand = '0;
        busy    = 1'b0;
        if (addr_valid(32'(addr), DEPTH, ZERO_REG)) begin
            if ((BYPASS != 0) && wr_ok && (wr_addr == addr)) begin
                operand = wr_data;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (addr == AW'(i)) begin
                        operand = regs[i*WIDTH +: WIDTH];
                        busy    = pend_bits[i];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Decode-stage register file with NRD combinational read ports and a per-register
// pending-write scoreboard set on issue and cleared on write-back.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter  int WIDTH    = DEFAULT_WIDTH,
    parameter  int DEPTH    = DEFAULT_DEPTH,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_pend,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr
);

    logic [DEPTH*WIDTH-1:0] regs;
    logic [DEPTH-1:0]       pend;
    logic                   wr_ok;
    logic                   iss_ok;

    // Gating with clear_n keeps the bypass path quiet while reset is held.
    assign wr_ok  = clear_n && wr_en && addr_valid(32'(wr_addr), DEPTH, ZERO_REG);
    assign iss_ok = iss_en && addr_valid(32'(iss_addr), DEPTH, ZERO_REG);

    // The issue assignment comes last so a same-cycle issue beats the write-back clear.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            regs <= '0;
            pend <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (wr_addr == AW'(i))) begin
                    regs[i*WIDTH +: WIDTH] <= wr_data;
                    pend[i]                <= 1'b0;
                end
                if (iss_ok && (iss_addr == AW'(i))) begin
                    pend[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        reg_file_rd_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .addr      (rd_addr[p*AW +: AW]),
            .regs      (regs),
            .pend_bits (pend),
            .wr_ok     (wr_ok),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .operand   (rd_data[p*WIDTH +: WIDTH]),
            .busy      (rd_pend[p])
        );
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench: two register-file instances (DEPTH 8 with bypass, DEPTH 6 without)
// share stimulus; a behavioural model queues expected read results for a negedge monitor.
module tb_reg_file_scoreboard;

    typedef struct {
        int          inst;
        int          port;
        int          addr;
        logic [31:0] data;
        logic        pend;
    } expect_t;

    logic        clk;
    logic        clear_n;
    logic [5:0]  rd_addr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [2:0]  iss_addr;
    logic [63:0] rd_data_a;
    logic [1:0]  rd_pend_a;
    logic [63:0] rd_data_b;
    logic [1:0]  rd_pend_b;

    expect_t     sb_q[$];
    int          n_compared;
    int          n_mismatched;

    logic [31:0] m_regs[2][8];
    bit          m_pend[2][8];
    int          depth_of[2]  = '{8, 6};
    int          bypass_of[2] = '{1, 0};

    reg_file_scoreboard #(.WIDTH(32), .DEPTH(8), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
        .clk(clk), .clear_n(clear_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_pend(rd_pend_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr)
    );

    reg_file_scoreboard #(.WIDTH(32), .DEPTH(6), .NRD(2), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
        .clk(clk), .clear_n(clear_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pend(rd_pend_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit modelValid(int k, int addr);
        return (addr < depth_of[k]) && (addr != 0);
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 8; r++) begin
                m_regs[k][r] = '0;
                m_pend[k][r] = 1'b0;
            end
    endtask

    // Clock-edge effect of the current inputs: write-back clears pending, issue sets it afterwards.
    task automatic modelUpdate();
        for (int k = 0; k < 2; k++) begin
            if (wr_en && modelValid(k, int'(wr_addr))) begin
                m_regs[k][wr_addr] = wr_data;
                m_pend[k][wr_addr] = 1'b0;
            end
            if (iss_en && modelValid(k, int'(iss_addr)))
                m_pend[k][iss_addr] = 1'b1;
        end
    endtask

    task automatic pushExpected();
        expect_t e;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                e.inst = k;
                e.port = p;
                e.addr = int'(rd_addr[p*3 +: 3]);
                if (!modelValid(k, e.addr)) begin
                    e.data = '0;
                    e.pend = 1'b0;
                end else if (bypass_of[k] != 0 && clear_n && wr_en && int'(wr_addr) == e.addr) begin
                    e.data = wr_data;
                    e.pend = 1'b0;
                end else begin
                    e.data = m_regs[k][e.addr];
                    e.pend = m_pend[k][e.addr];
                end
                sb_q.push_back(e);
            end
    endtask

    task automatic applyStimulus(input logic we, input int wa, input logic [31:0] wd,
                                 input logic ie, input int ia, input int a0, input int a1);
        wr_en    = we;
        wr_addr  = 3'(wa);
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = 3'(ia);
        rd_addr  = {3'(a1), 3'(a0)};
        pushExpected();
        @(posedge clk);
        if (clear_n) modelUpdate();
        #1;
    endtask

    // Reset is asserted and released between clock edges; outputs are checked while it is low.
    task automatic pulseReset(input int a0, input int a1);
        wr_en   = 1'b0;
        iss_en  = 1'b0;
        rd_addr = {3'(a1), 3'(a0)};
        clear_n = 1'b0;
        modelReset();
        pushExpected();
        @(negedge clk);
        #1;
        clear_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input expect_t e);
        logic [31:0] got_data;
        logic        got_pend;
        if (e.inst == 0) begin
            got_data = rd_data_a[e.port*32 +: 32];
            got_pend = rd_pend_a[e.port];
        end else begin
            got_data = rd_data_b[e.port*32 +: 32];
            got_pend = rd_pend_b[e.port];
        end
        n_compared++;
        if (got_data !== e.data) begin
            n_mismatched++;
            $display("[TB] FAIL dut%0d.port%0d.data addr=%0d got %h want %h at %0t",
                     e.inst, e.port, e.addr, got_data, e.data, $time);
        end
        n_compared++;
        if (got_pend !== e.pend) begin
            n_mismatched++;
            $display("[TB] FAIL dut%0d.port%0d.pend addr=%0d got %b want %b at %0t",
                     e.inst, e.port, e.addr, got_pend, e.pend, $time);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        clear_n  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        rd_addr  = {3'd5, 3'd3};
        modelReset();
        #1;
        pushExpected();
        @(negedge clk);
        #1;
        clear_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] reset mid-run");
        applyStimulus(1, 3, 32'hDEADBEEF, 0, 0, 3, 1);
        applyStimulus(0, 0, 0, 1, 3, 3, 3);
        applyStimulus(0, 0, 0, 0, 0, 3, 3);
        pulseReset(3, 5);
        applyStimulus(0, 0, 0, 0, 0, 3, 2);

        $display("[TB] zero register");
        applyStimulus(1, 0, 32'h1234, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        $display("[TB] bypass");
        applyStimulus(1, 5, 32'h11, 0, 0, 1, 2);
        applyStimulus(1, 5, 32'h22, 0, 0, 5, 4);
        applyStimulus(0, 0, 0, 0, 0, 5, 5);

        $display("[TB] scoreboard");
        applyStimulus(0, 0, 0, 1, 2, 2, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 2, 2);
        applyStimulus(1, 2, 32'h7, 0, 0, 2, 1);
        applyStimulus(0, 0, 0, 0, 0, 2, 2);

        $display("[TB] issue and write-back together");
        applyStimulus(0, 0, 0, 1, 4, 4, 0);
        applyStimulus(1, 4, 32'hCAFE0004, 1, 4, 4, 4);
        applyStimulus(0, 0, 0, 0, 0, 4, 4);
        applyStimulus(1, 6, 32'h66, 1, 4, 4, 6);
        applyStimulus(0, 0, 0, 0, 0, 4, 6);

        $display("[TB] out-of-range address");
        applyStimulus(1, 7, 32'hA5A5A5A5, 1, 7, 7, 6);
        applyStimulus(0, 0, 0, 0, 0, 7, 6);
        for (int r = 0; r < 8; r += 2) applyStimulus(0, 0, 0, 0, 0, r, r + 1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            int wa;
            int a0;
            int a1;
            wa = int'($urandom_range(0, 7));
            a0 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 7));
            a1 = int'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0)
                pulseReset(a0, a1);
            else
                applyStimulus(1'($urandom_range(0, 1)), wa, $urandom,
                              1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)), a0, a1);
        end

        @(negedge clk);
        #1;
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain got %0d left want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
